// File: rtl/coin_credit_if.sv
// Coin/credit handshake bundle between the coin front end,
// the credit FSM and the dispense FSM.
interface coin_credit_if;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       btn_a;
    logic       btn_b;
    logic       cancel;
    logic       listo;
    logic [3:0] total;
    logic [1:0] seleccion;
    logic       coin_reject;
    logic       refund_valid;
    logic [3:0] refund_amount;
    logic       busy;

    modport master (
        output coin_valid, coin_value, btn_a, btn_b, cancel, listo,
        input  total, seleccion, coin_reject, refund_valid,
        input  refund_amount, busy
    );

    modport slave (
        input  coin_valid, coin_value, btn_a, btn_b, cancel, listo,
        output total, seleccion, coin_reject, refund_valid,
        output refund_amount, busy
    );
endinterface

// File: rtl/coin_credit_fsm.sv
// Credit accumulator and request latch feeding the dispense FSM.
// Handles cancel, overflow rejection and timeout refunds.
module coin_credit_fsm #(
    parameter int MAX_TOTAL      = 15,
    parameter int PRICE_A        = 5,
    parameter int PRICE_B        = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic          clk,
    input logic          rst,
    coin_credit_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;

    state_t        st_q, st_d;
    logic [3:0]    total_q, total_d;
    logic [1:0]    sel_q, sel_d;
    logic          rej_q, rej_d;
    logic          rv_q, rv_d;
    logic [3:0]    ra_q, ra_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;

    logic [2:0] amt;
    logic       amt_ok;
    logic [4:0] sum;
    logic       fits;
    logic [1:0] req;
    logic       afford;
    logic       tmo;
    logic       to_ref;

    always_comb begin
        amt = 3'd0;
        unique case (bus.coin_value)
            2'b00: amt = 3'd1;
            2'b01: amt = 3'd2;
            2'b10: amt = 3'd5;
            2'b11: amt = 3'd0;
        endcase
        amt_ok = (amt != 3'd0);
        // 5-bit sum so an overflowing coin cannot wrap into range
        sum  = 5'(total_q) + 5'(amt);
        fits = (sum <= 5'(MAX_TOTAL));
    end

    always_comb begin
        req    = 2'b00;
        afford = 1'b0;
        if (bus.btn_a && !bus.btn_b) begin
            req    = 2'b01;
            afford = (total_q >= 4'(PRICE_A));
        end else if (bus.btn_b && !bus.btn_a) begin
            req    = 2'b10;
            afford = (total_q >= 4'(PRICE_B));
        end
    end

    assign tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
    assign tmo     = (tmr_q == TLAST);

    always_comb begin
        st_d    = st_q;
        total_d = total_q;
        sel_d   = sel_q;
        rej_d   = 1'b0;
        rv_d    = 1'b0;
        ra_d    = 4'd0;
        tmr_d   = '0;
        to_ref  = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (bus.coin_valid) begin
                    if (amt_ok) begin
                        st_d    = CREDIT;
                        total_d = 4'(amt);
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            CREDIT: begin
                tmr_d = tmr_inc;
                if (bus.cancel) begin
                    rej_d  = bus.coin_valid;
                    to_ref = 1'b1;
                end else if (bus.coin_valid && amt_ok && fits) begin
                    total_d = sum[3:0];
                    tmr_d   = '0;
                end else if (bus.coin_valid) begin
                    rej_d  = 1'b1;
                    to_ref = tmo;
                end else if (afford) begin
                    st_d  = VEND;
                    sel_d = req;
                    tmr_d = '0;
                end else begin
                    to_ref = tmo;
                end
            end
            VEND: begin
                tmr_d = tmr_inc;
                rej_d = bus.coin_valid;
                if (bus.listo) begin
                    st_d    = IDLE;
                    total_d = 4'd0;
                    sel_d   = 2'b00;
                    tmr_d   = '0;
                end else begin
                    to_ref = tmo;
                end
            end
            REFUND: begin
                rej_d   = bus.coin_valid;
                st_d    = IDLE;
                total_d = 4'd0;
                sel_d   = 2'b00;
            end
            default: st_d = IDLE;
        endcase
        // credit stays visible on total during the refund cycle
        if (to_ref) begin
            st_d  = REFUND;
            rv_d  = 1'b1;
            ra_d  = total_q;
            sel_d = 2'b00;
            tmr_d = '0;
        end
        busy_d = (st_d == VEND) || (st_d == REFUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            total_q <= 4'd0;
            sel_q   <= 2'b00;
            rej_q   <= 1'b0;
            rv_q    <= 1'b0;
            ra_q    <= 4'd0;
            busy_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            st_q    <= st_d;
            total_q <= total_d;
            sel_q   <= sel_d;
            rej_q   <= rej_d;
            rv_q    <= rv_d;
            ra_q    <= ra_d;
            busy_q  <= busy_d;
            tmr_q   <= tmr_d;
        end
    end

    assign bus.total         = total_q;
    assign bus.seleccion     = sel_q;
    assign bus.coin_reject   = rej_q;
    assign bus.refund_valid  = rv_q;
    assign bus.refund_amount = ra_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: directed scenarios plus random traffic
// against a behavioural credit/refund model.
module tb_coin_credit_fsm;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    coin_credit_if bus ();

    coin_credit_fsm #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // model: mode 0 waiting, 1 collecting, 2 vending, 3 refunding
    int m_mode, m_tot, m_sel, m_rej, m_rv, m_ra, m_idle;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coin_worth(bit [1:0] v);
        int w[4] = '{1, 2, 5, 0};
        return w[v];
    endfunction

    task automatic refund_now();
        m_rv   = 1;
        m_ra   = m_tot;
        m_sel  = 0;
        m_mode = 3;
        m_idle = 0;
    endtask

    task automatic tick_or_timeout();
        m_idle++;
        if (m_idle >= T) refund_now();
    endtask

    task automatic model(bit r, bit cv, bit [1:0] v,
                         bit a, bit b, bit c, bit l);
        int w;
        int price;
        w = coin_worth(v);
        m_rej = 0;
        m_rv  = 0;
        m_ra  = 0;
        if (r) begin
            m_mode = 0; m_tot = 0; m_sel = 0; m_idle = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (cv && w > 0) begin
                    m_mode = 1; m_tot = w; m_idle = 0;
                end else if (cv) m_rej = 1;
            end
            1: begin
                price = a ? 5 : 6;
                if (c) begin
                    m_rej = cv;
                    refund_now();
                end else if (cv && w > 0 && m_tot + w <= 15) begin
                    m_tot += w;
                    m_idle = 0;
                end else if (cv) begin
                    m_rej = 1;
                    tick_or_timeout();
                end else if ((a != b) && m_tot >= price) begin
                    m_mode = 2;
                    m_sel  = a ? 1 : 2;
                    m_idle = 0;
                end else tick_or_timeout();
            end
            2: begin
                m_rej = cv;
                if (l) begin
                    m_mode = 0; m_tot = 0; m_sel = 0; m_idle = 0;
                end else tick_or_timeout();
            end
            default: begin
                m_rej = cv;
                m_mode = 0; m_tot = 0; m_sel = 0; m_idle = 0;
            end
        endcase
    endtask

    task automatic cyc(bit r, bit cv, bit [1:0] v,
                       bit a, bit b, bit c, bit l);
        rst            = r;
        bus.coin_valid = cv;
        bus.coin_value = v;
        bus.btn_a      = a;
        bus.btn_b      = b;
        bus.cancel     = c;
        bus.listo      = l;
        model(r, cv, v, a, b, c, l);
        @(posedge clk);
        @(negedge clk);
        chk("total", int'(bus.total), m_tot);
        chk("seleccion", int'(bus.seleccion), m_sel);
        chk("coin_reject", int'(bus.coin_reject), m_rej);
        chk("refund_valid", int'(bus.refund_valid), m_rv);
        chk("refund_amount", int'(bus.refund_amount), m_ra);
        chk("busy", int'(bus.busy), (m_mode >= 2) ? 1 : 0);
    endtask

    task automatic idle();
        cyc(0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic coin(bit [1:0] v);
        cyc(0, 1, v, 0, 0, 0, 0);
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_value = 2'b00;
        bus.btn_a      = 1'b0;
        bus.btn_b      = 1'b0;
        bus.cancel     = 1'b0;
        bus.listo      = 1'b0;
        @(negedge clk);

        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        chk("rst_total", int'(bus.total), 0);
        chk("rst_busy", int'(bus.busy), 0);

        coin(2'b10);
        coin(2'b00);
        chk("s1_total", int'(bus.total), 6);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        chk("s1_sel", int'(bus.seleccion), 2);
        chk("s1_busy", int'(bus.busy), 1);
        idle();
        cyc(0, 0, 2'b00, 0, 0, 0, 1);
        chk("s1_done", int'(bus.total), 0);

        coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b01);
        chk("s2_14", int'(bus.total), 14);
        coin(2'b01);
        chk("s2_rej", int'(bus.coin_reject), 1);
        chk("s2_hold", int'(bus.total), 14);
        coin(2'b00);
        chk("s2_15", int'(bus.total), 15);
        cyc(0, 0, 2'b00, 0, 0, 1, 0);
        idle();

        coin(2'b10);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        chk("s3_poor", int'(bus.seleccion), 0);
        cyc(0, 0, 2'b00, 1, 1, 0, 0);
        chk("s3_both", int'(bus.seleccion), 0);
        coin(2'b01);
        cyc(0, 1, 2'b00, 0, 0, 1, 0);
        chk("s4_rej", int'(bus.coin_reject), 1);
        chk("s4_amt", int'(bus.refund_amount), 7);
        idle();
        chk("s4_zero", int'(bus.total), 0);

        coin(2'b10);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        for (int i = 0; i < T; i++) idle();
        chk("s5_tmo", int'(bus.refund_valid), 1);
        chk("s5_amt", int'(bus.refund_amount), 5);
        idle();

        coin(2'b10);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        chk("s6_sel", int'(bus.seleccion), 0);
        chk("s6_busy", int'(bus.busy), 0);
        coin(2'b11);
        chk("s6_bad", int'(bus.coin_reject), 1);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(199) == 0),
                ($urandom_range(99) < 40),
                2'($urandom_range(3)),
                ($urandom_range(9) == 0),
                ($urandom_range(9) == 0),
                ($urandom_range(49) == 0),
                ($urandom_range(99) < 12));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
